// File: rtl/alu_op_arbiter_4bit.sv
// Two-requester round-robin sequencer for a shared combinational bitwise ALU.
// Accepts one op, holds ALU inputs for SETTLE cycles, then returns the result.
module alu_op_arbiter_4bit #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_vld,
  output logic [1:0]       o_req_rdy,
  input  logic [WIDTH-1:0] i_req0_op1,
  input  logic [WIDTH-1:0] i_req0_op2,
  input  logic [1:0]       i_req0_sel,
  input  logic [WIDTH-1:0] i_req1_op1,
  input  logic [WIDTH-1:0] i_req1_op2,
  input  logic [1:0]       i_req1_sel,
  output logic [WIDTH-1:0] o_alu_op1,
  output logic [WIDTH-1:0] o_alu_op2,
  output logic [1:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_dat,
  output logic [1:0]       o_rsp_vld,
  output logic [WIDTH-1:0] o_rsp_dat,
  input  logic [1:0]       i_rsp_rdy,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t           r_state;
  logic             r_ptr;
  logic             r_gnt;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_dat;

  logic             w_gnt;
  logic             w_take;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [1:0]       w_sel;

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    w_gnt = r_ptr;
    unique case (1'b1)
      (i_req_vld == 2'b01): w_gnt = 1'b0;
      (i_req_vld == 2'b10): w_gnt = 1'b1;
      default:              w_gnt = r_ptr;
    endcase
  end

  assign w_take = (r_state == S_IDLE) && (i_req_vld != 2'b00);
  assign w_op1  = w_gnt ? i_req1_op1 : i_req0_op1;
  assign w_op2  = w_gnt ? i_req1_op2 : i_req0_op2;
  assign w_sel  = w_gnt ? i_req1_sel : i_req0_sel;

  assign o_req_rdy = !w_take ? 2'b00 :
                     (w_gnt ? 2'b10 : 2'b01);
  assign o_rsp_vld = (r_state != S_RESP) ? 2'b00 :
                     (r_gnt ? 2'b10 : 2'b01);
  assign o_busy    = (r_state != S_IDLE);
  assign o_alu_op1 = r_op1;
  assign o_alu_op2 = r_op2;
  assign o_alu_sel = r_sel;
  assign o_rsp_dat = r_dat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_cnt   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_gnt   <= w_gnt;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_sel   <= w_sel;
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST) begin
            r_dat   <= i_alu_dat;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_rdy[r_gnt]) begin
            r_ptr   <= ~r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter_4bit.sv
// Scoreboard bench for alu_op_arbiter_4bit with a behavioural bitwise ALU.
// Covers SETTLE=1 and SETTLE=4 instances.
module tb_alu_op_arbiter_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld, req_rdy, rsp_vld, rsp_rdy;
  logic [3:0] r0a, r0b, r1a, r1b;
  logic [1:0] r0s, r1s;
  logic [3:0] alu_op1, alu_op2, alu_dat, rsp_dat;
  logic [1:0] alu_sel;
  logic       busy;

  logic [1:0] vld4, req_rdy4, rsp_vld4, rsp_rdy4;
  logic [3:0] a4, b4;
  logic [1:0] s4;
  logic [3:0] alu_op1_4, alu_op2_4, alu_dat4, rsp_dat4;
  logic [1:0] alu_sel_4;
  logic       busy4;
  logic       corrupt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         id;
    logic [3:0] dat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] golden(
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign alu_dat  = golden(alu_op1, alu_op2, alu_sel);
  assign alu_dat4 = corrupt ?
    ~golden(alu_op1_4, alu_op2_4, alu_sel_4) :
    golden(alu_op1_4, alu_op2_4, alu_sel_4);

  alu_op_arbiter_4bit #(.WIDTH(4), .SETTLE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(vld), .o_req_rdy(req_rdy),
    .i_req0_op1(r0a), .i_req0_op2(r0b), .i_req0_sel(r0s),
    .i_req1_op1(r1a), .i_req1_op2(r1b), .i_req1_sel(r1s),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .o_alu_sel(alu_sel), .i_alu_dat(alu_dat),
    .o_rsp_vld(rsp_vld), .o_rsp_dat(rsp_dat),
    .i_rsp_rdy(rsp_rdy), .o_busy(busy)
  );

  alu_op_arbiter_4bit #(.WIDTH(4), .SETTLE(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(vld4), .o_req_rdy(req_rdy4),
    .i_req0_op1(a4), .i_req0_op2(b4), .i_req0_sel(s4),
    .i_req1_op1(a4), .i_req1_op2(b4), .i_req1_sel(s4),
    .o_alu_op1(alu_op1_4), .o_alu_op2(alu_op2_4),
    .o_alu_sel(alu_sel_4), .i_alu_dat(alu_dat4),
    .o_rsp_vld(rsp_vld4), .o_rsp_dat(rsp_dat4),
    .i_rsp_rdy(rsp_rdy4), .o_busy(busy4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.id  = k;
    e.dat = k ? golden(r1a, r1b, r1s) : golden(r0a, r0b, r0s);
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_sb"}, 32'(q.size()), 1);
      return;
    end
    e = q.pop_front();
    check({tag, "_vld"}, rsp_vld, (e.id != 0) ? 2'b10 : 2'b01);
    check({tag, "_dat"}, rsp_dat, e.dat);
  endtask

  task automatic collect(input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rsp_vld != 2'b00) begin
        pop_chk(tag);
        got = 1'b1;
      end
    end
    if (!got) check({tag, "_to"}, {31'b0, got}, 1);
  endtask

  task automatic run_op(input int k, input logic [3:0] a,
                        input logic [3:0] b, input logic [1:0] s,
                        input string tag);
    bit g = 1'b0;
    @(posedge clk); #1;
    if (k != 0) begin r1a = a; r1b = b; r1s = s; vld = 2'b10; end
    else begin r0a = a; r0b = b; r0s = s; vld = 2'b01; end
    for (int c = 0; c < 20 && !g; c++) begin
      @(negedge clk);
      if (req_rdy == vld) begin
        push(k);
        g = 1'b1;
      end
      else begin
        @(posedge clk); #1;
      end
    end
    if (!g) check({tag, "_gnt"}, {31'b0, g}, 1);
    @(posedge clk); #1;
    vld = 2'b00;
    collect(tag);
  endtask

  initial begin
    logic [1:0] gnts [3];
    int ng;
    rst_n = 1'b0; vld = '0; rsp_rdy = '0;
    vld4 = '0; rsp_rdy4 = '0; corrupt = 1'b0;
    r0a = '0; r0b = '0; r0s = '0;
    r1a = '0; r1b = '0; r1s = '0;
    a4 = '0; b4 = '0; s4 = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", req_rdy, 2'b00);
    check("rst_rsp_vld", rsp_vld, 2'b00);
    check("rst_rsp_dat", rsp_dat, 4'h0);
    check("rst_op1", alu_op1, 4'h0);
    check("rst_op2", alu_op2, 4'h0);
    check("rst_sel", alu_sel, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single NOR op, SETTLE=1
    rsp_rdy = 2'b01;
    r0a = 4'h3; r0b = 4'h5; r0s = 2'b11; vld = 2'b01;
    @(negedge clk);
    check("t1_req_rdy", req_rdy, 2'b01);
    check("t1_busy_n", busy, 1'b0);
    push(0);
    @(posedge clk); #1;
    vld = 2'b00;
    @(negedge clk);
    check("t1_busy_e", busy, 1'b1);
    check("t1_aop1", alu_op1, 4'h3);
    check("t1_aop2", alu_op2, 4'h5);
    check("t1_asel", alu_sel, 2'b11);
    check("t1_vld_e", rsp_vld, 2'b00);
    @(negedge clk);
    check("t1_busy_r", busy, 1'b1);
    check("t1_dat8", rsp_dat, 4'h8);
    pop_chk("t1");
    @(negedge clk);
    check("t1_idle", busy, 1'b0);
    check("t1_hold", rsp_dat, 4'h8);

    // dual requests from reset: r0, r1, r0
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_rdy = 2'b11;
    r0a = 4'hC; r0b = 4'hA; r0s = 2'b00;
    r1a = 4'hF; r1b = 4'h1; r1s = 2'b10;
    vld = 2'b11;
    ng = 0;
    for (int c = 0; c < 30 && (ng < 3 || q.size() > 0); c++) begin
      @(negedge clk);
      if (req_rdy != 2'b00 && ng < 3) begin
        gnts[ng] = req_rdy;
        push(req_rdy[1] ? 1 : 0);
        ng++;
      end
      if (rsp_vld != 2'b00) pop_chk("t2");
      @(posedge clk); #1;
      if (ng >= 3) vld = 2'b00;
    end
    check("t2_ngnt", ng, 3);
    check("t2_g0", gnts[0], 2'b01);
    check("t2_g1", gnts[1], 2'b10);
    check("t2_g2", gnts[2], 2'b01);
    check("t2_drain", q.size(), 0);

    // response backpressure on r1
    rsp_rdy = 2'b00;
    r1a = 4'h1; r1b = 4'h2; r1s = 2'b01;
    r0a = 4'h6; r0b = 4'h3; r0s = 2'b00;
    vld = 2'b10;
    @(negedge clk);
    check("t3_req_rdy", req_rdy, 2'b10);
    push(1);
    @(posedge clk); #1;
    vld = 2'b01;
    rsp_rdy = 2'b01;
    @(negedge clk);
    check("t3_rdy_e", req_rdy, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_vld_h", rsp_vld, 2'b10);
      check("t3_dat_h", rsp_dat, 4'h3);
      check("t3_rdy_h", req_rdy, 2'b00);
      @(posedge clk); #1;
    end
    rsp_rdy = 2'b10;
    @(negedge clk);
    pop_chk("t3");
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_done", rsp_vld, 2'b00);
    check("t3_next", req_rdy, 2'b01);
    push(0);
    @(posedge clk); #1;
    vld = 2'b00;
    rsp_rdy = 2'b11;
    collect("t3b");

    // SETTLE=4 with early ALU corruption
    @(posedge clk); #1;
    a4 = 4'h9; b4 = 4'h6; s4 = 2'b10;
    vld4 = 2'b01; rsp_rdy4 = 2'b01;
    @(negedge clk);
    check("t4_req_rdy", req_rdy4, 2'b01);
    @(posedge clk); #1;
    vld4 = 2'b00;
    corrupt = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) corrupt = 1'b0;
      @(negedge clk);
      check("t4_op1", alu_op1_4, 4'h9);
      check("t4_op2", alu_op2_4, 4'h6);
      check("t4_sel", alu_sel_4, 2'b10);
      check("t4_vld_e", rsp_vld4, 2'b00);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t4_vld", rsp_vld4, 2'b01);
    check("t4_dat", rsp_dat4, 4'hF);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_idle", busy4, 1'b0);

    // reset pulse during EXEC
    @(posedge clk); #1;
    r0a = 4'hA; r0b = 4'h5; r0s = 2'b01;
    vld = 2'b01;
    @(negedge clk);
    check("t5_req_rdy", req_rdy, 2'b01);
    @(posedge clk); #1;
    vld = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_exec", busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_vld", rsp_vld, 2'b00);
    check("t5_busy", busy, 1'b0);
    check("t5_dat", rsp_dat, 4'h0);
    check("t5_op1", alu_op1, 4'h0);
    check("t5_op2", alu_op2, 4'h0);
    check("t5_sel", alu_sel, 2'b00);
    @(negedge clk);
    check("t5_vld2", rsp_vld, 2'b00);
    @(posedge clk); #1;
    r1a = 4'h7; r1b = 4'h7; r1s = 2'b10;
    vld = 2'b11;
    @(negedge clk);
    check("t5_ptr", req_rdy, 2'b01);
    push(0);
    @(posedge clk); #1;
    vld = 2'b00;
    collect("t5b");

    // exhaustive operands and selects, alternating requesters
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = 10'(i);
      run_op(i & 1, v[3:0], v[7:4], v[9:8], "t6");
    end
    check("t6_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
